// File: rtl/identifier_rx_if.sv
// Identifier receiver bus bundle: bit-timing inputs from the framer and the
// identifier results returned to it.
interface identifier_rx_if;
    logic        enable;
    logic        sample_point;
    logic        rx_bit;
    logic        sof_complete;
    logic        stuff_bit;
    logic [10:0] rx_identifier;
    logic [3:0]  bit_counter;
    logic        id_complete;
    logic        id_valid;

    modport master (
        output enable, sample_point, rx_bit, sof_complete, stuff_bit,
        input  rx_identifier, bit_counter, id_complete, id_valid
    );

    modport slave (
        input  enable, sample_point, rx_bit, sof_complete, stuff_bit,
        output rx_identifier, bit_counter, id_complete, id_valid
    );
endinterface

// File: rtl/identifier_rx.sv
// Collects the 11-bit frame identifier MSB first, skipping stuff bits, and
// flags whether the received identifier is legal.
module identifier_rx (
    input  logic            clock,
    input  logic            reset,
    identifier_rx_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  shift_reg;
    logic [10:0] id_reg;
    logic [3:0]  count_reg;
    logic        complete_reg;
    logic        valid_reg;
    logic        take_bit;

    assign take_bit = bus.sample_point && !bus.stuff_bit;

    // Identifiers whose top seven bits are all recessive are reserved and
    // reported as illegal; legality is decided from the bits being shifted in.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            id_reg       <= '0;
            count_reg    <= '0;
            complete_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else if (bus.enable) begin
            case (state)
                IDLE: begin
                    shift_reg    <= '0;
                    count_reg    <= '0;
                    complete_reg <= 1'b0;
                    valid_reg    <= 1'b0;
                    if (bus.sof_complete)
                        state <= RECEIVE;
                end
                RECEIVE: begin
                    if (!bus.sof_complete) begin
                        state     <= IDLE;
                        shift_reg <= '0;
                        count_reg <= '0;
                    end else if (take_bit) begin
                        shift_reg <= {shift_reg[8:0], bus.rx_bit};
                        count_reg <= count_reg + 4'd1;
                        if (count_reg == 4'd10) begin
                            state        <= COMPLETE;
                            id_reg       <= {shift_reg, bus.rx_bit};
                            complete_reg <= 1'b1;
                            valid_reg    <= (shift_reg[9:3] != 7'h7F);
                        end
                    end
                end
                COMPLETE: begin
                    if (!bus.sof_complete) begin
                        state        <= IDLE;
                        shift_reg    <= '0;
                        count_reg    <= '0;
                        complete_reg <= 1'b0;
                        valid_reg    <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    shift_reg    <= '0;
                    count_reg    <= '0;
                    complete_reg <= 1'b0;
                    valid_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_identifier = id_reg;
    assign bus.bit_counter   = count_reg;
    assign bus.id_complete   = complete_reg;
    assign bus.id_valid      = valid_reg;
endmodule
